// File: rtl/uart_word_loader.sv
// UART receiver that packs four bytes into a big-endian word and strobes sequential word writes.
// Define UART_PARITY_EN to receive 8E1 frames instead of 8N1.
module uart_word_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  Rx_Serial,
    output logic                  word_valid,
    output logic [ADDR_WIDTH-1:0] word_addr,
    output logic [31:0]           word_data,
    output logic                  done,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CLEANUP} rx_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} rx_state_t;
`endif

    rx_state_t        state, state_next;
    logic             rx_meta, rx_s;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       rx_byte, rx_byte_next;
    logic             parity_ok;
    logic             accept_byte, reject_byte;
    logic [1:0]       byte_cnt;
    logic [23:0]      pending;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= Rx_Serial;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            rx_byte <= '0;
        end else begin
            state   <= state_next;
            clk_cnt <= clk_cnt_next;
            bit_idx <= bit_idx_next;
            rx_byte <= rx_byte_next;
        end
    end

`ifdef UART_PARITY_EN
    logic parity_bit, parity_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_bit <= 1'b0;
        end else begin
            parity_bit <= parity_next;
        end
    end

    // Even parity: data bits plus parity bit must XOR to zero.
    assign parity_ok = ~(^{rx_byte, parity_bit});
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt;
        bit_idx_next = bit_idx;
        rx_byte_next = rx_byte;
        accept_byte  = 1'b0;
        reject_byte  = 1'b0;
`ifdef UART_PARITY_EN
        parity_next  = parity_bit;
`endif
        if (!en) begin
            state_next   = IDLE;
            clk_cnt_next = '0;
            bit_idx_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    clk_cnt_next = '0;
                    bit_idx_next = '0;
                    if (!rx_s) begin
                        state_next = START;
                    end
                end
                START: begin
                    // A line that is high again at mid-start-bit was only a glitch.
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt_next = '0;
                        state_next   = rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt_next = clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt_next = '0;
                        rx_byte_next = {rx_s, rx_byte[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            bit_idx_next = bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt_next = clk_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt_next = '0;
                        parity_next  = rx_s;
                        state_next   = STOP;
                    end else begin
                        clk_cnt_next = clk_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt_next = '0;
                        state_next   = CLEANUP;
                        if (rx_s && parity_ok) begin
                            accept_byte = ~done;
                        end else begin
                            reject_byte = 1'b1;
                        end
                    end else begin
                        clk_cnt_next = clk_cnt + 1'b1;
                    end
                end
                CLEANUP: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Word assembly, write strobe and address sequencing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt   <= '0;
            pending    <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            word_addr  <= '0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
        end else if (!en) begin
            byte_cnt   <= '0;
            word_valid <= 1'b0;
            word_addr  <= '0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (reject_byte) begin
                frame_err <= 1'b1;
            end
            if (accept_byte) begin
                pending  <= {pending[15:0], rx_byte};
                byte_cnt <= byte_cnt + 1'b1;
                if (byte_cnt == 2'd3) begin
                    word_data  <= {pending, rx_byte};
                    word_valid <= 1'b1;
                end
            end
            if (word_valid) begin
                word_addr <= word_addr + 1'b1;
                if (word_addr == ADDR_LAST) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_word_loader.sv
// Randomized self-checking bench for uart_word_loader against a byte/word queue model.
module tb_uart_word_loader;

    localparam int CPB   = 4;
    localparam int AW    = 2;
    localparam int WORDS = 1 << AW;
`ifdef UART_PARITY_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } strobe_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          rx_serial = 1'b1;
    logic          word_valid;
    logic [AW-1:0] word_addr;
    logic [31:0]   word_data;
    logic          done;
    logic          frame_err;

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    int strobe_count = 0;
    logic [31:0]   last_data = '0;
    logic [AW-1:0] last_addr = '0;

    logic [7:0] model_bytes[$];
    strobe_t    expected_q[$];
    int         model_addr = 0;
    bit         model_done = 1'b0;
    bit         model_frame_err = 1'b0;

    uart_word_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .Rx_Serial(rx_serial),
        .word_valid(word_valid),
        .word_addr(word_addr),
        .word_data(word_data),
        .done(done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Model: a frame either is rejected (sticky error) or contributes one byte; four bytes make a word.
    task automatic model_frame(input logic [7:0] data, input bit good);
        strobe_t s;
        if (!good) begin
            model_frame_err = 1'b1;
        end else if (!model_done) begin
            model_bytes.push_back(data);
            if (model_bytes.size() == 4) begin
                s.addr = AW'(model_addr);
                s.data = {model_bytes[0], model_bytes[1], model_bytes[2], model_bytes[3]};
                expected_q.push_back(s);
                model_bytes.delete();
                model_addr = (model_addr + 1) % WORDS;
                if (model_addr == 0) model_done = 1'b1;
            end
        end
    endtask

    task automatic model_clear();
        model_bytes.delete();
        model_addr      = 0;
        model_done      = 1'b0;
        model_frame_err = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        rx_serial = b;
        repeat (CPB) @(negedge clk);
    endtask

    // Sends one frame; abort_bits >= 0 drops en after that many data bits.
    task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit,
                                  input logic par_bit, input int abort_bits);
        bit good;
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (abort_bits == i) begin
                en        = 1'b0;
                rx_serial = 1'b1;
                model_clear();
                return;
            end
            drive_bit(data[i]);
        end
        if (PARITY_ON) drive_bit(par_bit);
        good = stop_bit && (!PARITY_ON || ((^data ^ par_bit) == 1'b0));
        model_frame(data, good);
        drive_bit(stop_bit);
        rx_serial = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] data);
        apply_stimulus(data, 1'b1, ^data, -1);
    endtask

    task automatic check_output(input string tag);
        check_value({tag, "_pending_strobes"}, 32'(expected_q.size()), 32'd0);
        check_value({tag, "_addr"}, 32'(word_addr), 32'(model_addr));
        check_value({tag, "_done"}, 32'(done), 32'(model_done));
        check_value({tag, "_frame_err"}, 32'(frame_err), 32'(model_frame_err));
    endtask

    task automatic clear_loader();
        @(negedge clk);
        en = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
    endtask

    // Every strobe must match the oldest word the model has produced.
    always @(negedge clk) begin
        strobe_t e;
        cycle++;
        if (cycle > 60000) begin
            $display("[TB] FAIL watchdog actual=%0d cycles required<=60000", cycle);
            $fatal(1, "[TB] watchdog expired");
        end
        if (reset && word_valid) begin
            strobe_count++;
            last_data = word_data;
            last_addr = word_addr;
            if (expected_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_strobe actual addr=0x%0h data=0x%0h required=no strobe",
                         word_addr, word_data);
            end else begin
                e = expected_q.pop_front();
                check_value("strobe_addr", 32'(word_addr), 32'(e.addr));
                check_value("strobe_data", word_data, e.data);
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic       stop;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_value("reset_word_valid", 32'(word_valid), 32'd0);
        check_value("reset_word_addr", 32'(word_addr), 32'd0);
        check_value("reset_word_data", word_data, 32'd0);
        check_value("reset_done", 32'(done), 32'd0);
        check_value("reset_frame_err", 32'(frame_err), 32'd0);

        reset = 1'b1;
        en    = 1'b1;
        repeat (100) @(negedge clk);
        check_value("idle_strobes", 32'(strobe_count), 32'd0);
        check_value("idle_word_data", word_data, 32'd0);
        check_output("idle");

        send_good(8'hDE);
        send_good(8'hAD);
        send_good(8'hBE);
        send_good(8'hEF);
        check_output("first_word");
        check_value("deadbeef_data", last_data, 32'hDEADBEEF);
        check_value("deadbeef_addr", 32'(last_addr), 32'd0);

        for (int i = 0; i < 12; i++) send_good(8'($urandom_range(0, 255)));
        check_output("fill");
        check_value("fill_done", 32'(done), 32'd1);
        check_value("fill_addr", 32'(word_addr), 32'd0);
        check_value("fill_strobes", 32'(strobe_count), 32'd4);
        send_good(8'($urandom_range(0, 255)));
        check_value("after_done_strobes", 32'(strobe_count), 32'd4);
        check_output("after_done");

        clear_loader();
        check_output("cleared");
        d = 8'h12;
        apply_stimulus(d, 1'b0, ^d, -1);
        send_good(8'h34);
        send_good(8'h56);
        send_good(8'h78);
        send_good(8'h9A);
        check_output("bad_stop");
        check_value("bad_stop_frame_err", 32'(frame_err), 32'd1);
        check_value("bad_stop_data", last_data, 32'h3456789A);
        check_value("bad_stop_addr", 32'(last_addr), 32'd0);

        @(negedge clk);
        rx_serial = 1'b0;
        @(negedge clk);
        rx_serial = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) send_good(8'($urandom_range(0, 255)));
        check_output("glitch");
        check_value("glitch_addr", 32'(last_addr), 32'd1);

        send_good(8'($urandom_range(0, 255)));
        d = 8'($urandom_range(0, 255));
        apply_stimulus(d, 1'b1, ^d, 3);
        repeat (3 * CPB) @(negedge clk);
        check_output("en_drop");
        en = 1'b1;
        for (int i = 0; i < 4; i++) send_good(8'($urandom_range(0, 255)));
        check_output("en_restart");
        check_value("en_restart_addr", 32'(last_addr), 32'd0);

        for (int i = 0; i < 24; i++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 7) != 0);
            apply_stimulus(d, stop, ^d, -1);
        end
        check_output("random");

`ifdef UART_PARITY_EN
        clear_loader();
        apply_stimulus(8'h01, 1'b1, 1'b0, -1);
        check_value("parity_bad_frame_err", 32'(frame_err), 32'd1);
        apply_stimulus(8'h01, 1'b1, 1'b1, -1);
        send_good(8'h22);
        send_good(8'h33);
        send_good(8'h44);
        check_output("parity");
        check_value("parity_data", last_data, 32'h01223344);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_word_loader.md
# uart_word_loader

Serial-to-memory loader that sits directly upstream of the data and instruction memories' UART write port. It receives 8N1 bytes on `Rx_Serial`, packs four bytes into a 32-bit word, and issues one single-cycle write strobe per word with an auto-incrementing word address. After the last word of the memory has been written, it raises a sticky `done` flag for the LED status display.

## Interface
- `CLKS_PER_BIT`, default 868: `clk` cycles per UART bit (100 MHz / 115200). Must be ≥ 4.
- `ADDR_WIDTH`, default 10: word-address width; the load length is 2^ADDR_WIDTH words.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `en`  input  1  loader enable; low holds and clears the loader synchronously.
- `Rx_Serial`  input  1  UART receive line; idle high; asynchronous to `clk`.
- `word_valid`  output  1  one-cycle write strobe for `word_addr`/`word_data`.
- `word_addr`  output  ADDR_WIDTH  word address of the current or next write.
- `word_data`  output  32  assembled word.
- `done`  output  1  sticky: the final address has been written.
- `frame_err`  output  1  sticky: a framing error (or parity error, see Configuration) has been seen.

## Operation
- `Rx_Serial` passes through a 2-flop synchronizer; only the synchronized value `rx_s` is used.
- Receive FSM:
  - IDLE: on `rx_s`=0 → START; bit counter cleared.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If 0 → DATA; if 1 (glitch) → IDLE.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, shifted into `rx_byte`. After bit 7 → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample. If 1, the byte is accepted. If 0, set `frame_err`, discard the byte, and leave `byte_cnt` unchanged. Either way → CLEANUP.
  - CLEANUP: one cycle → IDLE.
- Word packing:
  - Big-endian order. The first accepted byte goes to `word_data[31:24]` and the fourth to `[7:0]`.
  - `byte_cnt` (2 bits) increments on each accepted byte.
  - On the 4th byte, the cycle after the STOP sample, `word_valid`=1 for exactly one cycle with `word_addr` equal to the current address. `word_data` holds until the next word completes.
- Address:
  - Increments on the cycle after `word_valid`.
  - If `word_valid` fires at address 2^ADDR_WIDTH−1, `done` is set and the address wraps to 0.
  - While `done`=1, the FSM still runs but no byte is accepted and `word_valid` never fires.
- `en`=0 forces IDLE and clears `byte_cnt`, `word_addr`, `done` and `frame_err` on the next edge. A frame in progress is dropped.
- Reset values: `word_valid`=0, `word_addr`=0, `word_data`=0, `done`=0, `frame_err`=0, FSM=IDLE, synchronizer flops=1.

## Timing
- Line-to-FSM latency: 2 cycles (synchronizer).
- STOP sample: 1.5 × CLKS_PER_BIT + 8 × CLKS_PER_BIT cycles after START entry. `word_valid` follows one cycle later.
- Minimum spacing between `word_valid` pulses: 4 frames (~40 × CLKS_PER_BIT cycles). Consumers need no backpressure.
- If `en` falls in the same cycle that `word_valid` would fire, `en` wins: no strobe, all state cleared.
- Reset assertion mid-frame immediately returns the block to the reset values. The FSM resumes at the next falling edge after release.

## Configuration
- `UART_PARITY_EN`:
  - Defined: the frame is 8E1. A PARITY state sits between DATA and STOP and samples one extra bit. If XOR of the 8 data bits and the parity bit ≠ 0, `frame_err` is set and the byte is discarded, as for a bad stop bit.
  - Undefined: the frame is 8N1 as described above, and the PARITY state and its logic are absent.

## Test plan
Bench parameters: CLKS_PER_BIT=4, ADDR_WIDTH=2, parity disabled unless stated.

- Reset then idle line, 100 cycles → all outputs 0; `word_valid` never asserts.
- Send bytes 0xDE, 0xAD, 0xBE, 0xEF → a single `word_valid` pulse with `word_addr`=0 and `word_data`=0xDEADBEEF.
- Send 16 bytes (4 words) → strobes at addresses 0, 1, 2, 3 in order. `done`=1 after the 4th strobe and `word_addr`=0. A 17th byte produces no strobe.
- Send 0x12 with stop bit driven 0, then 0x34, 0x56, 0x78, 0x9A → `frame_err`=1. One strobe with `word_data`=0x3456789A.
- Send a 1-cycle low glitch on `Rx_Serial`, and separately drop `en` in the middle of the 2nd byte → the glitch produces no byte accepted. After `en` is re-raised, the next 4 bytes give a strobe at `word_addr`=0.
- With `UART_PARITY_EN` defined, send 0x01 with parity bit 0 → `frame_err`=1 and the byte is discarded. The same byte with parity bit 1 is accepted.
